// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and default constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  // Controller states: normal operation, waiting on I$ or D$, and the
  // terminal watchdog state that only reset can leave.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IMISS = 2'd1,
    ST_DMISS = 2'd2,
    ST_HUNG  = 2'd3
  } state_t;

  localparam int DEF_REG_ADDR_W  = 5;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use, taken-branch and cache-miss stall
// generation with a miss watchdog and a saturating stall-cycle counter.
//
// Handshake note: icache_ready / dcache_ready are level "can complete this
// cycle" qualifiers; the hazard outputs respond in the same cycle and the
// pipeline advances on a rising edge only when the relevant stall is low.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter bit X0_HARDWIRED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_ready,
  input  logic                  dcache_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  flush_ifid,
  output logic                  bubble_idex,
  output logic                  stall_all,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  timeout,
  output state_t                dbg_state
);

  // Watchdog only needs to reach TIMEOUT_CYC-1; the trip fires on the
  // cycle whose increment would land on that value.
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_TRIP = WD_W'(TIMEOUT_CYC - 2);

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            load_use;
  logic            miss_pending;
  logic            any_stall;

  assign load_use = ex_mem_read
                  && ((ex_rd == id_rs1) || (ex_rd == id_rs2))
                  && !(X0_HARDWIRED && (ex_rd == '0));

  // Same-cycle hazard response, resolved strictly by priority.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    stall_all   = 1'b0;
    if (!rst) begin
      if ((state_q == ST_HUNG) || !dcache_ready) begin
        stall_all = 1'b1;
      end else if (branch_taken) begin
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
        stall_pc    = !icache_ready;
      end else if (load_use) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end else if (!icache_ready) begin
        stall_pc   = 1'b1;
        flush_ifid = 1'b1;
      end
    end
  end

  // Next state, watchdog and sticky timeout; the watchdog overrides all.
  always_comb begin
    state_d      = state_q;
    wd_d         = '0;
    timeout_d    = timeout_q;
    miss_pending = ((state_q == ST_IMISS) && !icache_ready && dcache_ready)
                || ((state_q == ST_DMISS) && !dcache_ready);
    if (miss_pending) begin
      wd_d = wd_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (!dcache_ready) begin
          state_d = ST_DMISS;
        end else if (!icache_ready && !branch_taken && !load_use) begin
          state_d = ST_IMISS;
        end
      end
      ST_IMISS: begin
        if (!dcache_ready) begin
          state_d = ST_DMISS;
        end else if (icache_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_DMISS: begin
        if (dcache_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_HUNG: state_d = ST_HUNG;
      default: state_d = ST_IDLE;
    endcase
    if (miss_pending && (wd_q == WD_TRIP)) begin
      state_d   = ST_HUNG;
      timeout_d = 1'b1;
      wd_d      = '0;
    end
  end

  // Controller state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign any_stall = stall_pc | stall_ifid | bubble_idex | stall_all;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .clr    (rst),
    .inc    (any_stall),
    .count_o(stall_cycles)
  );

  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two parameterisations driven in lockstep,
// a per-cycle behavioural model, and a few hand-computed pinned checks.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int M_IDLE = 0, M_IMISS = 1, M_DMISS = 2, M_HUNG = 3;

  // clock / reset and shared stimulus
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       icache_ready = 1'b1, dcache_ready = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       ex_mem_read = 1'b0, branch_taken = 1'b0;

  always #5 clk = ~clk;

  // instance A: defaults; instance B: tiny counter, short watchdog, no x0 rule
  logic        a_pc, a_ifid, a_flush, a_bub, a_all, a_to;
  logic [31:0] a_cnt;
  state_t      a_st;
  logic        b_pc, b_ifid, b_flush, b_bub, b_all, b_to;
  logic [2:0]  b_cnt;
  state_t      b_st;

  pipeline_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .icache_ready(icache_ready), .dcache_ready(dcache_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .stall_pc(a_pc), .stall_ifid(a_ifid),
    .flush_ifid(a_flush), .bubble_idex(a_bub), .stall_all(a_all),
    .stall_cycles(a_cnt), .timeout(a_to), .dbg_state(a_st)
  );

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(5), .CNT_W(3), .TIMEOUT_CYC(4), .X0_HARDWIRED(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .icache_ready(icache_ready), .dcache_ready(dcache_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .stall_pc(b_pc), .stall_ifid(b_ifid),
    .flush_ifid(b_flush), .bubble_idex(b_bub), .stall_all(b_all),
    .stall_cycles(b_cnt), .timeout(b_to), .dbg_state(b_st)
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: per instance state, pending-miss run length, counters
  int     p_to[2] = '{1024, 4};
  int     p_cw[2] = '{32, 3};
  bit     p_x0[2] = '{1'b1, 1'b0};
  int     m_st[2] = '{0, 0};
  int     m_run[2] = '{0, 0};
  longint m_cnt[2] = '{0, 0};
  bit     m_to[2] = '{1'b0, 1'b0};

  // expected {stall_pc, stall_ifid, flush_ifid, bubble_idex, stall_all}
  function automatic logic [4:0] exp_haz(int k);
    bit lu;
    lu = ex_mem_read && ((ex_rd == id_rs1) || (ex_rd == id_rs2))
         && !(p_x0[k] && (ex_rd == 5'd0));
    if (rst)                            return 5'b00000;
    if (m_st[k] == M_HUNG || !dcache_ready) return 5'b00001;
    if (branch_taken)                   return {!icache_ready, 1'b0, 1'b1, 1'b1, 1'b0};
    if (lu)                             return 5'b11010;
    if (!icache_ready)                  return 5'b10100;
    return 5'b00000;
  endfunction

  // advance the model across the coming rising edge
  function automatic void model_step(int k, logic [4:0] e);
    bit lu, pend;
    longint cmax;
    if (rst) begin
      m_st[k] = M_IDLE; m_run[k] = 0; m_cnt[k] = 0; m_to[k] = 1'b0;
      return;
    end
    cmax = (longint'(1) << p_cw[k]) - 1;
    if ((e != 5'b0) && (m_cnt[k] < cmax)) m_cnt[k]++;
    if (m_st[k] == M_HUNG) return;
    lu = ex_mem_read && ((ex_rd == id_rs1) || (ex_rd == id_rs2))
         && !(p_x0[k] && (ex_rd == 5'd0));
    pend = (m_st[k] == M_IMISS && !icache_ready && dcache_ready)
        || (m_st[k] == M_DMISS && !dcache_ready);
    if (pend) begin
      m_run[k]++;
      if (m_run[k] == p_to[k] - 1) begin
        m_st[k] = M_HUNG; m_to[k] = 1'b1; m_run[k] = 0;
        return;
      end
    end else begin
      m_run[k] = 0;
    end
    if (m_st[k] == M_DMISS)      m_st[k] = dcache_ready ? M_IDLE : M_DMISS;
    else if (!dcache_ready)      m_st[k] = M_DMISS;
    else if (m_st[k] == M_IMISS) m_st[k] = icache_ready ? M_IDLE : M_IMISS;
    else if (!icache_ready && !branch_taken && !lu) m_st[k] = M_IMISS;
    else                         m_st[k] = M_IDLE;
  endfunction

  // compare process: every cycle, both instances against the model
  always @(negedge clk) begin
    logic [4:0] ea, eb;
    ea = exp_haz(0);
    eb = exp_haz(1);
    chk("a.hazard", {a_pc, a_ifid, a_flush, a_bub, a_all}, ea);
    chk("a.stall_cycles", a_cnt, m_cnt[0]);
    chk("a.timeout", a_to, m_to[0]);
    chk("b.hazard", {b_pc, b_ifid, b_flush, b_bub, b_all}, eb);
    chk("b.stall_cycles", b_cnt, m_cnt[1]);
    chk("b.timeout", b_to, m_to[1]);
    model_step(0, ea);
    model_step(1, eb);
  end

  // driver: apply one cycle of inputs just after the rising edge
  task automatic drive(input bit r, input bit ic, input bit dc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input bit mr, input bit br);
    @(posedge clk);
    #1;
    rst = r; icache_ready = ic; dcache_ready = dc;
    id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; ex_mem_read = mr; branch_taken = br;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // two reset cycles with hostile inputs; outputs must stay low throughout
  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1);
    @(negedge clk);
    chk("rst.a.hazard", {a_pc, a_ifid, a_flush, a_bub, a_all}, 5'b0);
    drive(1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst.b.hazard", {b_pc, b_ifid, b_flush, b_bub, b_all}, 5'b0);
    chk("rst.a.cnt", a_cnt, 0);
    chk("rst.b.to", b_to, 0);
    chk("rst.a.state", a_st, ST_IDLE);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    bit ic, dc;
    do_reset();

    // load-use on rs2
    drive(1'b0, 1'b1, 1'b1, 5'd3, 5'd5, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    chk("lu.a.hazard", {a_pc, a_ifid, a_flush, a_bub, a_all}, 5'b11010);
    idle();
    @(negedge clk);
    chk("lu.a.cnt", a_cnt, 1);

    // x0 exemption (instance A only)
    drive(1'b0, 1'b1, 1'b1, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("x0.a.hazard", {a_pc, a_ifid, a_flush, a_bub, a_all}, 5'b00000);
    chk("x0.b.hazard", {b_pc, b_ifid, b_flush, b_bub, b_all}, 5'b11010);

    // branch beats load-use
    drive(1'b0, 1'b1, 1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1);
    @(negedge clk);
    chk("br.a.hazard", {a_pc, a_ifid, a_flush, a_bub, a_all}, 5'b00110);

    // three-cycle dcache miss
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("dm.a.hazard", {a_pc, a_ifid, a_flush, a_bub, a_all}, 5'b00001);
    end
    idle();
    @(negedge clk);
    chk("dm.a.release", a_all, 0);
    idle();
    @(negedge clk);
    chk("dm.a.state", a_st, ST_IDLE);
    chk("dm.a.cnt", a_cnt, 3);

    // watchdog on instance B with icache held off
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("wd.b.timeout", b_to, (i == 5) ? 1 : 0);
      chk("wd.b.hazard", {b_pc, b_ifid, b_flush, b_bub, b_all},
          (i == 5) ? 5'b00001 : 5'b10100);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      @(negedge clk);
      chk("wd.b.hung", {b_all, b_to}, 2'b11);
    end

    // counter saturation on instance B
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    end
    idle();
    @(negedge clk);
    chk("sat.b.cnt", b_cnt, 7);
    chk("sat.a.cnt", a_cnt, 10);
    idle();
    @(negedge clk);
    chk("sat.b.hold", b_cnt, 7);

    // randomized traffic with bursty misses and occasional resets
    do_reset();
    ic = 1'b1;
    dc = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      ic = ic ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 9) < 3);
      dc = dc ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 4);
      drive($urandom_range(0, 59) == 0, ic, dc, pick_reg(), pick_reg(), pick_reg(),
            $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
    end
    idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
